// File: rtl/alu_pkg.sv
// Shared ALU definitions: mod-sequencer state encoding, opcode constant and default datapath width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam logic [2:0] ALU_OP_MOD = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } mod_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mod_step.sv
// One restoring remainder step: shift in the next dividend bit, trial-subtract the divisor, keep on no borrow.
module mod_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_next
);

    logic [WIDTH:0]   t;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    // t keeps the remainder MSB so a divisor above 2^(WIDTH-1) still compares correctly.
    assign t        = {rem, dvd_bit};
    assign diff     = {1'b0, t} - {2'b00, dsr};
    assign borrow   = diff[WIDTH+1];
    assign rem_next = WIDTH'(borrow ? t : diff[WIDTH:0]);

endmodule

// File: rtl/mod_sequencer.sv
// Multi-cycle unsigned a mod b for the ALU mod slot; one remainder bit per cycle.
// Optional `cycles` output (latency of the last operation) is enabled by MOD_SEQ_CYCLE_CNT_EN.
module mod_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
`ifdef MOD_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]      cycles
`endif
);

    localparam int ITER_W = $clog2(WIDTH + 1);

    mod_state_e       state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [ITER_W-1:0] iter_q;
    logic [WIDTH-1:0] rem_next;
    logic             last_iter;

    mod_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_bit  (dvd_q[WIDTH-1]),
        .dsr      (dsr_q),
        .rem_next (rem_next)
    );

    assign last_iter = (iter_q == ITER_W'(WIDTH - 1));

    // NOTE: every register here uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            iter_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q   <= a;
                        dsr_q   <= b;
                        busy    <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (dsr_q == '0) begin
                        result   <= dvd_q;
                        div_zero <= 1'b1;
                        done     <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        rem_q    <= '0;
                        iter_q   <= '0;
                        div_zero <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    dvd_q  <= dvd_q << 1;
                    rem_q  <= rem_next;
                    iter_q <= iter_q + 1'b1;
                    if (last_iter) begin
                        result  <= rem_next;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MOD_SEQ_CYCLE_CNT_EN
    // cnt_q holds the index of the current cycle relative to the accepting edge.
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            cycles <= '0;
        end else begin
            case (state_q)
                IDLE:  if (start) cnt_q <= 16'd1;
                CHECK: begin
                    if (dsr_q == '0) cycles <= sat_inc16(cnt_q);
                    else             cnt_q  <= sat_inc16(cnt_q);
                end
                RUN: begin
                    cnt_q <= sat_inc16(cnt_q);
                    if (last_iter) cycles <= sat_inc16(cnt_q);
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mod_sequencer.sv
// Self-checking bench for mod_sequencer: reference model built from a % b and the latency rules.
module tb_mod_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_zero;
`ifdef MOD_SEQ_CYCLE_CNT_EN
    logic [15:0]      cycles;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    mod_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
`ifdef MOD_SEQ_CYCLE_CNT_EN
        ,
        .cycles   (cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks cycles since acceptance and applies the output rules directly.
    bit          m_busy = 0, m_done = 0, m_dz = 0;
    logic [31:0] m_result = '0, m_a = '0, m_b = '0;
    logic [15:0] m_cycles = '0;
    int          m_el = 0, m_lat = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_dz = 0;
            m_result = '0; m_cycles = '0; m_el = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_el++;
                if (m_el == 2) m_dz = (m_b == 0);
                if (m_el == m_lat) begin
                    m_done   = 1;
                    m_result = (m_b == 0) ? m_a : m_a % m_b;
                    m_cycles = 16'(m_lat);
                end
                if (m_el == m_lat + 1) m_busy = 0;
            end else if (start) begin
                m_busy = 1;
                m_el   = 1;
                m_a    = a;
                m_b    = b;
                m_lat  = (b == 0) ? 2 : WIDTH + 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_done", 32'(done), 32'(m_done));
            check("model_div_zero", 32'(div_zero), 32'(m_dz));
            check("model_result", result, m_result);
`ifdef MOD_SEQ_CYCLE_CNT_EN
            check("model_cycles", 32'(cycles), 32'(m_cycles));
`endif
        end
    end

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] exp_res,
                          input bit exp_dz, input int exp_lat, input int inject_at);
        int  n;
        bit  seen;
        seen = 0;
        @(negedge clk);
        start = 1; a = av; b = bv;
        for (n = 1; n <= WIDTH + 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 0; a = $urandom; b = $urandom;
                check("busy_after_accept", 32'(busy), 32'd1);
            end
            if (n == inject_at) begin
                start = 1; a = 32'd9; b = 32'd4;
            end else if (inject_at != 0 && n == inject_at + 1) begin
                start = 0;
            end
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_latency", seen ? 32'(n) : 32'hDEAD, 32'(exp_lat));
        check("result_literal", result, exp_res);
        check("div_zero_literal", 32'(div_zero), 32'(exp_dz));
`ifdef MOD_SEQ_CYCLE_CNT_EN
        check("cycles_literal", 32'(cycles), 32'(exp_lat));
`endif
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_single_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1;

        run_op(32'd17, 32'd5, 32'd2, 1'b0, 34, 0);
        run_op(32'd5, 32'd17, 32'd5, 1'b0, 34, 0);
        run_op(32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 34, 0);
        run_op(32'hFFFFFFFF, 32'h10000, 32'hFFFF, 1'b0, 34, 0);
        run_op(32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0, 34, 0);
        run_op(32'h1234, 32'd0, 32'h1234, 1'b1, 2, 0);
        run_op(32'd100, 32'd7, 32'd2, 1'b0, 34, 10);
        run_op(32'd0, 32'd9, 32'd0, 1'b0, 34, 0);

        // Reset in the middle of a running operation.
        @(negedge clk);
        start = 1; a = 32'd1000; b = 32'd3;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (n == 1) start = 0;
            if (n == 15) rst_n = 0;
        end
        @(negedge clk);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_div_zero", 32'(div_zero), 32'd0);
        check("midreset_result", result, 32'd0);
        rst_n = 1;
        run_op(32'd1000, 32'd3, 32'd1, 1'b0, 34, 0);
        run_op(32'd12345, 32'd0, 32'd12345, 1'b1, 2, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
